// File: rtl/snn_potential_mem_ctrl.sv
// Membrane-potential store and spike generator for one SNN core.
// Serves potentials to the adder, takes back sums, thresholds them and emits spikes.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 one-cycle pulse that begins a run from IDLE or DONE
//   pot_valid/ready/data  stored potential {1'b0, pot[7:0]} offered to the adder
//   in_valid/ready/data   sum packet coming back from the NoC
//   spk_valid/ready/data  spike packet sent toward the NoC
//   busy, done            run status
//   err_cnt               dropped packets, saturating at 8'hFF
module snn_potential_mem_ctrl #(
  parameter int         NEURON_CNT = 25,
  parameter int         TIMESTEPS  = 10,
  parameter logic [8:0] THRESH     = 9'd64,
  parameter logic [3:0] MY_ADDR    = 4'd0,
  parameter logic [3:0] ADDER_ADDR = 4'd1,
  parameter logic [3:0] SPK_DEST   = 4'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        pot_valid,
  input  logic        pot_ready,
  output logic [8:0]  pot_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        spk_valid,
  input  logic        spk_ready,
  output logic [31:0] spk_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_POT,
    S_WAIT_SUM,
    S_SPIKE,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(NEURON_CNT - 1);
  localparam logic [3:0] LAST_TS  = 4'(TIMESTEPS - 1);

  state_t state, state_d;
  logic [5:0] idx, idx_d;
  logic [3:0] ts, ts_d;

  // Sized to the full 6-bit neuron index; only NEURON_CNT entries are used.
  logic [7:0] pot_mem [64];

  logic [3:0] pkt_dest;
  logic [3:0] pkt_src;
  logic [1:0] pkt_type;
  logic [5:0] pkt_nrn;
  logic [8:0] pkt_sum;
  logic       pkt_good;
  logic       sum_fire;
  logic       unused_rsvd;

  logic pot_xfer;
  logic in_xfer;
  logic spk_xfer;

  logic        pot_valid_d;
  logic [8:0]  pot_data_d;
  logic        in_ready_d;
  logic        spk_valid_d;
  logic [31:0] spk_data_d;
  logic        busy_d;
  logic        done_d;

  assign pkt_dest    = in_data[31:28];
  assign pkt_src     = in_data[27:24];
  assign pkt_type    = in_data[23:22];
  assign pkt_nrn     = in_data[21:16];
  assign pkt_sum     = in_data[8:0];
  assign unused_rsvd = ^in_data[15:9];

  assign pkt_good = (pkt_dest == MY_ADDR)
                 && (pkt_src == ADDER_ADDR)
                 && (pkt_type == 2'b00)
                 && (pkt_nrn == idx);
  assign sum_fire = (pkt_sum >= THRESH);

  assign pot_xfer = pot_valid && pot_ready;
  assign in_xfer  = in_valid && in_ready;
  assign spk_xfer = spk_valid && spk_ready;

  // State, counters, potential memory and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      ts        <= '0;
      err_cnt   <= '0;
      pot_valid <= 1'b0;
      pot_data  <= '0;
      in_ready  <= 1'b0;
      spk_valid <= 1'b0;
      spk_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < NEURON_CNT; i++) begin
        pot_mem[i[5:0]] <= '0;
      end
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      ts        <= ts_d;
      pot_valid <= pot_valid_d;
      pot_data  <= pot_data_d;
      in_ready  <= in_ready_d;
      spk_valid <= spk_valid_d;
      spk_data  <= spk_data_d;
      busy      <= busy_d;
      done      <= done_d;
      if (in_xfer) begin
        if (pkt_good) begin
          pot_mem[idx] <= sum_fire ? 8'd0 : pkt_sum[7:0];
        end else if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

  // Next-state and sequencing counters.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    ts_d    = ts;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SEND_POT;
          idx_d   = '0;
          ts_d    = '0;
        end
      end
      S_SEND_POT: begin
        if (pot_xfer) state_d = S_WAIT_SUM;
      end
      S_WAIT_SUM: begin
        if (in_xfer && pkt_good) begin
          state_d = sum_fire ? S_SPIKE : S_NEXT;
        end
      end
      S_SPIKE: begin
        if (spk_xfer) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx == LAST_IDX) begin
          idx_d   = '0;
          ts_d    = ts + 4'd1;
          state_d = (ts == LAST_TS) ? S_DONE : S_SEND_POT;
        end else begin
          idx_d   = idx + 6'd1;
          state_d = S_SEND_POT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they appear
  // registered in the same cycle the state is entered.
  always_comb begin
    pot_valid_d = (state_d == S_SEND_POT);
    in_ready_d  = (state_d == S_WAIT_SUM);
    spk_valid_d = (state_d == S_SPIKE);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    pot_data_d  = '0;
    spk_data_d  = '0;
    if (pot_valid_d) begin
      pot_data_d = {1'b0, pot_mem[idx_d]};
    end
    if (spk_valid_d) begin
      spk_data_d = {SPK_DEST, MY_ADDR, 2'b11, idx_d,
                    3'b000, ts_d, 9'h001};
    end
  end

endmodule

// File: tb/tb_snn_potential_mem_ctrl.sv
// Bench for snn_potential_mem_ctrl: directed literal runs plus
// randomized runs checked every cycle against a transaction-level model.
module tb_snn_potential_mem_ctrl;

  localparam int N = 3;
  localparam int T = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        pot_valid;
  logic        pot_ready;
  logic [8:0]  pot_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        spk_valid;
  logic        spk_ready;
  logic [31:0] spk_data;
  logic        busy;
  logic        done;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  snn_potential_mem_ctrl #(
    .NEURON_CNT(N),
    .TIMESTEPS (T)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pot_valid(pot_valid),
    .pot_ready(pot_ready),
    .pot_data (pot_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .spk_valid(spk_valid),
    .spk_ready(spk_ready),
    .spk_data (spk_data),
    .busy     (busy),
    .done     (done),
    .err_cnt  (err_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  // Transaction-level model: what the block should be offering and when.
  typedef enum {P_IDLE, P_POT, P_SUM, P_SPK, P_DONE} ph_t;
  ph_t        m_ph;
  logic [7:0] m_pot [64];
  logic [5:0] m_idx;
  logic [3:0] m_ts;
  int         m_err;
  int         m_vis;
  int         cyc = 0;
  bit         m_known = 1'b0;
  bit         settled;
  logic [8:0] m_sum;

  function automatic void advance();
    if (int'(m_idx) == N - 1) begin
      m_idx = '0;
      m_ph  = (int'(m_ts) == T - 1) ? P_DONE : P_POT;
      m_ts  = m_ts + 4'd1;
    end else begin
      m_idx = m_idx + 6'd1;
      m_ph  = P_POT;
    end
    m_vis = cyc + 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_known = 1'b1;
      m_ph    = P_IDLE;
      m_idx   = '0;
      m_ts    = '0;
      m_err   = 0;
      m_vis   = cyc;
      for (int i = 0; i < 64; i++) m_pot[i] = '0;
    end else if (m_known) begin
      settled = (cyc - 1 >= m_vis);
      if (settled && start && (m_ph == P_IDLE || m_ph == P_DONE)) begin
        m_ph  = P_POT;
        m_idx = '0;
        m_ts  = '0;
        m_vis = cyc;
      end else if (settled) begin
        case (m_ph)
          P_POT: if (pot_ready) begin
            m_ph  = P_SUM;
            m_vis = cyc;
          end
          P_SUM: if (in_valid) begin
            m_sum = in_data[8:0];
            if (in_data[31:28] == 4'd0 && in_data[27:24] == 4'd1 &&
                in_data[23:22] == 2'b00 && in_data[21:16] == m_idx) begin
              if (m_sum >= 9'd64) begin
                m_pot[m_idx] = '0;
                m_ph  = P_SPK;
                m_vis = cyc;
              end else begin
                m_pot[m_idx] = m_sum[7:0];
                advance();
              end
            end else if (m_err < 255) begin
              m_err++;
            end
          end
          P_SPK: if (spk_ready) advance();
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  logic        e_pv, e_ir, e_sv, e_busy, e_done;
  logic [8:0]  e_pd;
  logic [31:0] e_sd;
  always @(negedge clk) begin
    if (m_known) begin
      e_pv = 0; e_ir = 0; e_sv = 0; e_busy = 1; e_done = 0;
      e_pd = '0; e_sd = '0;
      if (cyc >= m_vis) begin
        case (m_ph)
          P_IDLE: e_busy = 0;
          P_DONE: begin e_busy = 0; e_done = 1; end
          P_POT:  begin e_pv = 1; e_pd = {1'b0, m_pot[m_idx]}; end
          P_SUM:  e_ir = 1;
          P_SPK:  begin
            e_sv = 1;
            e_sd = {4'hF, 4'h0, 2'b11, m_idx, 3'b000, m_ts, 9'h001};
          end
          default: ;
        endcase
      end
      chk("cycle",
          {pot_valid, (e_pv ? pot_data : 9'd0), in_ready, spk_valid,
           (e_sv ? spk_data : 32'd0), busy, done, err_cnt},
          {e_pv, e_pd, e_ir, e_sv, e_sd, e_busy, e_done, 8'(m_err)});
    end
  end

  function automatic logic [31:0] good_pkt(input logic [5:0] id,
                                           input logic [8:0] s);
    return {4'h0, 4'h1, 2'b00, id, 7'd0, s};
  endfunction

  function automatic logic [31:0] bad_pkt(input logic [5:0] id,
                                          input logic [8:0] s);
    logic [31:0] p;
    p = good_pkt(id, s);
    case ($urandom_range(0, 3))
      0: p[31:28] = 4'h3;
      1: p[27:24] = 4'h2;
      2: p[23:22] = 2'b10;
      default: p[21:16] = id ^ 6'd1;
    endcase
    return p;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_pot(input bit lit, input logic [8:0] exp, input int stall);
    int k;
    repeat (stall) @(negedge clk);
    pot_ready = 1'b1;
    k = 0;
    while (pot_valid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) timeout("pot_wait");
    else if (lit) chk("pot_data", 64'(pot_data), 64'(exp));
    @(negedge clk);
    pot_ready = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] p);
    int k;
    in_data  = p;
    in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) timeout("in_wait");
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic do_spike(input bit lit, input logic [31:0] exp,
                          input int stall, input bit poke);
    int k;
    k = 0;
    while (spk_valid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) timeout("spk_wait");
    else if (lit) chk("spk_data", 64'(spk_data), 64'(exp));
    for (int s = 0; s < stall; s++) begin
      if (poke && s == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (lit) chk("spk_hold", {spk_valid, spk_data, in_ready, pot_valid},
                   {1'b1, exp, 2'b00});
    end
    spk_ready = 1'b1;
    @(negedge clk);
    spk_ready = 1'b0;
  endtask

  task automatic neuron(input bit lit, input logic [8:0] ep,
                        input logic [5:0] id, input logic [8:0] s,
                        input int nbad, input int stall,
                        input logic [31:0] espk);
    do_pot(lit, ep, stall);
    repeat (nbad) send_pkt(bad_pkt(id, s));
    send_pkt(good_pkt(id, s));
    if (s >= 9'd64) do_spike(lit, espk, stall, stall > 1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) timeout("done_wait");
    else chk("done_busy", {done, busy}, 2'b10);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pot_ready = 1'b0;
    in_valid = 1'b0; in_data = '0; spk_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_state", {pot_valid, in_ready, spk_valid, busy, done,
                        err_cnt, pot_data, spk_data}, 64'd0);

    // Reset while waiting for a sum.
    pulse_start();
    do_pot(1, 9'd0, 0);
    chk("t1_in_wait", 64'(in_ready), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t1_after_rst", {pot_valid, in_ready, spk_valid, busy, done,
                         err_cnt, pot_data, spk_data}, 64'd0);

    // Directed run with literal expectations.
    pulse_start();
    do_pot(1, 9'd0, 1);
    send_pkt({4'h0, 4'h2, 2'b00, 6'd0, 7'd0, 9'd5});
    send_pkt({4'h0, 4'h1, 2'b00, 6'd3, 7'd0, 9'd5});
    chk("t4_err_cnt", 64'(err_cnt), 64'd2);
    chk("t4_still_wait", {in_ready, pot_valid, spk_valid}, 3'b100);
    send_pkt(good_pkt(6'd0, 9'd10));
    neuron(1, 9'd0,  6'd1, 9'd64,  0, 5, 32'hF0C10001);
    neuron(1, 9'd0,  6'd2, 9'd20,  0, 0, 32'h0);
    neuron(1, 9'd10, 6'd0, 9'd100, 0, 1, 32'hF0C00201);
    neuron(1, 9'd0,  6'd1, 9'd5,   0, 0, 32'h0);
    neuron(1, 9'd20, 6'd2, 9'd255, 0, 2, 32'hF0C20201);
    wait_done();

    // Rerun: potentials persist across runs.
    pulse_start();
    neuron(1, 9'd0, 6'd0, 9'd1, 0, 0, 32'h0);
    neuron(1, 9'd5, 6'd1, 9'd2, 0, 0, 32'h0);
    neuron(1, 9'd0, 6'd2, 9'd3, 0, 0, 32'h0);
    neuron(1, 9'd1, 6'd0, 9'd4, 0, 0, 32'h0);
    neuron(1, 9'd2, 6'd1, 9'd5, 0, 0, 32'h0);
    neuron(1, 9'd3, 6'd2, 9'd6, 0, 0, 32'h0);
    wait_done();
    chk("rerun_err", 64'(err_cnt), 64'd2);

    // Randomized runs checked by the per-cycle model.
    for (int r = 0; r < 5; r++) begin
      pulse_start();
      for (int t = 0; t < T; t++) begin
        for (int n = 0; n < N; n++) begin
          logic [8:0] s;
          s = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(256, 511))
                                          : 9'($urandom_range(0, 130));
          neuron(0, 9'd0, 6'(n), s,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                 int'($urandom_range(0, 3)), 32'h0);
        end
      end
      wait_done();
    end

    // Error counter saturation.
    pulse_start();
    do_pot(0, 9'd0, 0);
    repeat (260) send_pkt(bad_pkt(6'd0, 9'd1));
    chk("err_saturate", 64'(err_cnt), 64'hFF);
    send_pkt(good_pkt(6'd0, 9'd7));
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
